// File: rtl/envelope_engine.sv
// rtl/envelope_engine.sv - time-multiplexed ADSR envelope generator
// One slot per cycle: key-edge retrigger, saturating rate steps, frame-divided level updates.
module envelope_engine #(
  parameter int NUM_VOICES    = 16,
  parameter int NUM_OPERATORS = 6,
  parameter int LEVEL_WIDTH   = 16,
  parameter int TICK_DIV      = 128,
  localparam int NUM_SLOTS    = NUM_VOICES * NUM_OPERATORS,
  localparam int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_SlotValid,
  input  logic [SLOT_W-1:0]      i_Slot,
  input  logic                   i_KeyOn,
  input  logic [LEVEL_WIDTH-1:0] i_AttackRate,
  input  logic [LEVEL_WIDTH-1:0] i_AttackLevel,
  input  logic [LEVEL_WIDTH-1:0] i_DecayRate,
  input  logic [LEVEL_WIDTH-1:0] i_SustainLevel,
  input  logic [LEVEL_WIDTH-1:0] i_ReleaseRate,
  output logic                   o_Valid,
  output logic [SLOT_W-1:0]      o_Slot,
  output logic [LEVEL_WIDTH-1:0] o_Level,
  output logic [2:0]             o_State,
  output logic                   o_Update
);

  localparam int FC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [FC_W-1:0]   FC_LAST    = FC_W'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W:0]   SLOT_LIMIT = (SLOT_W + 1)'(NUM_SLOTS);

  typedef enum logic [2:0] {
    ST_MUTE = 3'd0,
    ST_ATT  = 3'd1,
    ST_DEC  = 3'd2,
    ST_SUS  = 3'd3,
    ST_REL  = 3'd4
  } state_t;

  state_t                 r_state [NUM_SLOTS];
  logic [LEVEL_WIDTH-1:0] r_level [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   r_key;
  logic [FC_W-1:0]        r_FrameCount;

  logic                   in_range;
  logic                   accept;
  logic [SLOT_W-1:0]      rd_idx;
  state_t                 cur_state;
  logic [LEVEL_WIDTH-1:0] cur_level;
  logic                   prev_key;
  logic                   update;
  state_t                 nxt_state;
  logic [LEVEL_WIDTH-1:0] nxt_level;
  logic [LEVEL_WIDTH:0]   att_sum;

  assign in_range  = ({1'b0, i_Slot} < SLOT_LIMIT);
  assign accept    = i_SlotValid && in_range;
  assign rd_idx    = in_range ? i_Slot : '0;
  assign cur_state = r_state[rd_idx];
  assign cur_level = r_level[rd_idx];
  assign prev_key  = r_key[rd_idx];
  assign update    = (r_FrameCount == FC_LAST);
  // One extra bit so the attack step saturates instead of wrapping.
  assign att_sum   = {1'b0, cur_level} + {1'b0, i_AttackRate};

  always_comb begin
    nxt_state = cur_state;
    nxt_level = cur_level;
    if (i_KeyOn && !prev_key) begin
      nxt_state = ST_ATT;
    end else if (!i_KeyOn && (prev_key || cur_state == ST_ATT ||
                              cur_state == ST_DEC || cur_state == ST_SUS)) begin
      nxt_state = ST_REL;
    end
    // Arithmetic follows the post-key-event state so an edge and an update share one visit.
    if (update) begin
      case (nxt_state)
        ST_ATT: begin
          if (att_sum >= {1'b0, i_AttackLevel}) begin
            nxt_level = i_AttackLevel;
            nxt_state = ST_DEC;
          end else begin
            nxt_level = att_sum[LEVEL_WIDTH-1:0];
          end
        end
        ST_DEC: begin
          if (cur_level <= i_SustainLevel || (cur_level - i_SustainLevel) <= i_DecayRate) begin
            nxt_level = i_SustainLevel;
            nxt_state = ST_SUS;
          end else begin
            nxt_level = cur_level - i_DecayRate;
          end
        end
        ST_SUS: nxt_level = i_SustainLevel;
        ST_REL: begin
          if (cur_level <= i_ReleaseRate) begin
            nxt_level = '0;
            nxt_state = ST_MUTE;
          end else begin
            nxt_level = cur_level - i_ReleaseRate;
          end
        end
        default: nxt_level = '0;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= ST_MUTE;
        r_level[i] <= '0;
      end
      r_key        <= '0;
      r_FrameCount <= '0;
      o_Valid      <= 1'b0;
      o_Slot       <= '0;
      o_Level      <= '0;
      o_State      <= 3'd0;
      o_Update     <= 1'b0;
    end else begin
      o_Valid <= accept;
      if (accept) begin
        r_state[i_Slot] <= nxt_state;
        r_level[i_Slot] <= nxt_level;
        r_key[i_Slot]   <= i_KeyOn;
        o_Slot          <= i_Slot;
        o_Level         <= nxt_level;
        o_State         <= nxt_state;
        o_Update        <= update;
        if (i_Slot == SLOT_LAST) begin
          r_FrameCount <= (r_FrameCount == FC_LAST) ? '0 : r_FrameCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_envelope_engine.sv
// tb/tb_envelope_engine.sv - scoreboard bench for envelope_engine
// Three instances: 4 slots with TICK_DIV 1 and 4, plus a 5-slot one exposing out-of-range indices.
module tb_envelope_engine;

  localparam logic [2:0] MUTE = 3'd0, ATT = 3'd1, DEC = 3'd2, SUS = 3'd3, REL = 3'd4;

  typedef struct {
    logic [2:0]  slot;
    logic [15:0] level;
    logic [2:0]  state;
    logic        upd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        key = 1'b0;
  logic [2:0]  slot3 = 3'd0;
  logic [15:0] ar = '0, al = '0, dr = '0, sl = '0, rr = '0;

  logic        d1_valid, d4_valid, dx_valid;
  logic [1:0]  d1_slot, d4_slot;
  logic [2:0]  dx_slot;
  logic [15:0] d1_level, d4_level, dx_level;
  logic [2:0]  d1_state, d4_state, dx_state;
  logic        d1_upd, d4_upd, dx_upd;

  logic        obs_valid, obs_upd;
  logic [2:0]  obs_slot, obs_state;
  logic [15:0] obs_level;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   sel = 0;
  int   upd_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  envelope_engine #(.NUM_VOICES(2), .NUM_OPERATORS(2), .LEVEL_WIDTH(16), .TICK_DIV(1)) u_dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SlotValid(valid), .i_Slot(slot3[1:0]), .i_KeyOn(key),
    .i_AttackRate(ar), .i_AttackLevel(al), .i_DecayRate(dr), .i_SustainLevel(sl),
    .i_ReleaseRate(rr), .o_Valid(d1_valid), .o_Slot(d1_slot), .o_Level(d1_level),
    .o_State(d1_state), .o_Update(d1_upd));

  envelope_engine #(.NUM_VOICES(2), .NUM_OPERATORS(2), .LEVEL_WIDTH(16), .TICK_DIV(4)) u_dut4 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SlotValid(valid), .i_Slot(slot3[1:0]), .i_KeyOn(key),
    .i_AttackRate(ar), .i_AttackLevel(al), .i_DecayRate(dr), .i_SustainLevel(sl),
    .i_ReleaseRate(rr), .o_Valid(d4_valid), .o_Slot(d4_slot), .o_Level(d4_level),
    .o_State(d4_state), .o_Update(d4_upd));

  envelope_engine #(.NUM_VOICES(5), .NUM_OPERATORS(1), .LEVEL_WIDTH(16), .TICK_DIV(1)) u_dutx (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_SlotValid(valid), .i_Slot(slot3), .i_KeyOn(key),
    .i_AttackRate(ar), .i_AttackLevel(al), .i_DecayRate(dr), .i_SustainLevel(sl),
    .i_ReleaseRate(rr), .o_Valid(dx_valid), .o_Slot(dx_slot), .o_Level(dx_level),
    .o_State(dx_state), .o_Update(dx_upd));

  always_comb begin
    obs_valid = d1_valid; obs_slot = {1'b0, d1_slot}; obs_level = d1_level;
    obs_state = d1_state; obs_upd = d1_upd;
    if (sel == 1) begin
      obs_valid = d4_valid; obs_slot = {1'b0, d4_slot}; obs_level = d4_level;
      obs_state = d4_state; obs_upd = d4_upd;
    end else if (sel == 2) begin
      obs_valid = dx_valid; obs_slot = dx_slot; obs_level = dx_level;
      obs_state = dx_state; obs_upd = dx_upd;
    end
  end

  always @(negedge clk)
    if (sel == 1 && obs_valid && obs_slot == 3'd0 && obs_upd) upd_cnt++;

  // Sweeps slots 0..3 back to back; only slot 0 ever gets a key, the rest stay muted.
  task automatic run_frame(input string name, input int dsel, input logic k0,
                           input logic [15:0] lvl0, input logic [2:0] st0, input logic upd);
    exp_t e;
    sel = dsel;
    for (int s = 0; s < 4; s++) begin
      valid = 1'b1;
      slot3 = 3'(s);
      key   = (s == 0) ? k0 : 1'b0;
      e.slot  = 3'(s);
      e.level = (s == 0) ? lvl0 : 16'h0;
      e.state = (s == 0) ? st0 : MUTE;
      e.upd   = upd;
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (obs_valid !== 1'b1 || obs_slot !== e.slot || obs_level !== e.level ||
          obs_state !== e.state || obs_upd !== e.upd) begin
        tests_failed++;
        $display("FAIL %s slot%0d: got v=%b slot=%0d lvl=%h st=%0d upd=%b, want v=1 slot=%0d lvl=%h st=%0d upd=%b",
                 name, s, obs_valid, obs_slot, obs_level, obs_state, obs_upd,
                 e.slot, e.level, e.state, e.upd);
      end
    end
    valid = 1'b0;
  endtask

  task automatic pulse_reset(input string name);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    key   = 1'b0;
    #1;
    tests_run++;
    if ({d1_valid, d1_slot, d1_level, d1_state, d1_upd} !== 23'h0) begin
      tests_failed++;
      $display("FAIL %s dut1: got v=%b slot=%0d lvl=%h st=%0d upd=%b, want all 0",
               name, d1_valid, d1_slot, d1_level, d1_state, d1_upd);
    end
    tests_run++;
    if ({d4_valid, d4_slot, d4_level, d4_state, d4_upd} !== 23'h0) begin
      tests_failed++;
      $display("FAIL %s dut4: got v=%b slot=%0d lvl=%h st=%0d upd=%b, want all 0",
               name, d4_valid, d4_slot, d4_level, d4_state, d4_upd);
    end
    tests_run++;
    if ({dx_valid, dx_slot, dx_level, dx_state, dx_upd} !== 24'h0) begin
      tests_failed++;
      $display("FAIL %s dutx: got v=%b slot=%0d lvl=%h st=%0d upd=%b, want all 0",
               name, dx_valid, dx_slot, dx_level, dx_state, dx_upd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pulse_reset("reset_state");
    @(negedge clk);
    tests_run++;
    if ({d1_valid, d1_level, d1_state, d1_upd} !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_idle: got v=%b lvl=%h st=%0d upd=%b, want all 0",
               d1_valid, d1_level, d1_state, d1_upd);
    end
  endtask

  task automatic test_attack();
    ar = 16'h4000; al = 16'hC000; dr = 16'h0; sl = 16'h0; rr = 16'h0;
    run_frame("attack1", 0, 1'b1, 16'h4000, ATT, 1'b1);
    run_frame("attack2", 0, 1'b1, 16'h8000, ATT, 1'b1);
    run_frame("attack3", 0, 1'b1, 16'hC000, DEC, 1'b1);
    run_frame("decay_rate0_hold", 0, 1'b1, 16'hC000, DEC, 1'b1);
  endtask

  task automatic test_decay();
    dr = 16'h3000; sl = 16'h7000;
    run_frame("decay1", 0, 1'b1, 16'h9000, DEC, 1'b1);
    run_frame("decay_to_sus", 0, 1'b1, 16'h7000, SUS, 1'b1);
    sl = 16'h6000;
    run_frame("sus_track", 0, 1'b1, 16'h6000, SUS, 1'b1);
    sl = 16'h7000;
    run_frame("sus_track_back", 0, 1'b1, 16'h7000, SUS, 1'b1);
  endtask

  task automatic test_release();
    rr = 16'h5000;
    run_frame("release1", 0, 1'b0, 16'h2000, REL, 1'b1);
    run_frame("release_floor", 0, 1'b0, 16'h0000, MUTE, 1'b1);
    run_frame("mute_hold", 0, 1'b0, 16'h0000, MUTE, 1'b1);
  endtask

  task automatic test_retrigger();
    rr = 16'h2000;
    run_frame("retrig_press", 0, 1'b1, 16'h4000, ATT, 1'b1);
    run_frame("retrig_release", 0, 1'b0, 16'h2000, REL, 1'b1);
    run_frame("retrig_continue", 0, 1'b1, 16'h6000, ATT, 1'b1);
    ar = 16'h0;
    run_frame("attack_rate0_hold", 0, 1'b1, 16'h6000, ATT, 1'b1);
  endtask

  task automatic test_saturation();
    ar = 16'hF000; al = 16'hFFFF;
    run_frame("attack_no_wrap", 0, 1'b1, 16'hFFFF, DEC, 1'b1);
    rr = 16'h1000;
    run_frame("release_from_top", 0, 1'b0, 16'hEFFF, REL, 1'b1);
    al = 16'h8000;
    run_frame("attack_above_peak", 0, 1'b1, 16'h8000, DEC, 1'b1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sel = 0;
    dr = 16'h1000; sl = 16'h0;
    valid = 1'b1; slot3 = 3'd0; key = 1'b1;
    e.slot = 3'd0; e.level = 16'h7000; e.state = DEC; e.upd = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    e.level = 16'h6000;
    exp_q.push_back(e);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (d1_valid !== 1'b1 || {1'b0, d1_slot} !== e.slot || d1_level !== e.level ||
          d1_state !== e.state) begin
        tests_failed++;
        $display("FAIL back_to_back%0d: got v=%b lvl=%h st=%0d, want v=1 lvl=%h st=%0d",
                 i, d1_valid, d1_level, d1_state, e.level, e.state);
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_midframe();
    valid = 1'b1; slot3 = 3'd0; key = 1'b1;
    @(negedge clk);
    slot3 = 3'd1; key = 1'b0;
    pulse_reset("reset_midframe");
    run_frame("post_reset_mute", 0, 1'b0, 16'h0, MUTE, 1'b1);
  endtask

  task automatic test_out_of_range();
    exp_t e;
    sel = 2;
    valid = 1'b1; slot3 = 3'd5; key = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_slot5: got o_Valid=%b, want 0", dx_valid);
    end
    slot3 = 3'd7;
    @(negedge clk);
    tests_run++;
    if (dx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_slot7: got o_Valid=%b, want 0", dx_valid);
    end
    slot3 = 3'd0; key = 1'b0;
    e.slot = 3'd0; e.level = 16'h0; e.state = MUTE; e.upd = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dx_valid !== 1'b1 || dx_slot !== e.slot || dx_level !== e.level || dx_state !== e.state) begin
      tests_failed++;
      $display("FAIL oor_slot0_untouched: got v=%b slot=%0d lvl=%h st=%0d, want v=1 slot=0 lvl=%h st=%0d",
               dx_valid, dx_slot, dx_level, dx_state, e.level, e.state);
    end
    valid = 1'b0;
  endtask

  task automatic test_tick_div();
    logic [15:0] lvl;
    sel = 1;
    ar = 16'h1000; al = 16'hC000; dr = 16'h0; sl = 16'h0; rr = 16'h0;
    valid = 1'b1; slot3 = 3'd0; key = 1'b1;
    @(negedge clk);
    slot3 = 3'd1;
    pulse_reset("tick_reset_midframe");
    upd_cnt = 0;
    for (int f = 0; f < 16; f++) begin
      lvl = 16'h1000 * 16'((f + 1) / 4);
      run_frame($sformatf("tick_div_f%0d", f), 1, 1'b1, lvl, ATT, (f % 4) == 3);
    end
    tests_run++;
    if (upd_cnt !== 4) begin
      tests_failed++;
      $display("FAIL tick_div_update_count: got %0d, want 4", upd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_release();
    test_retrigger();
    test_saturation();
    test_back_to_back();
    test_reset_midframe();
    test_out_of_range();
    test_tick_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
